// File: rtl/mux_scan_nx1.sv
// rtl/mux_scan_nx1.sv - registered N-to-1 mux with channel mask and round-robin auto scan
// Manual mode is a direct registered select; auto mode dwells dwell+1 cycles per eligible channel.
module mux_scan_nx1 #(
  parameter int NUM_CH = 8,
  parameter int WIDTH  = 4,
  parameter int SEL_W  = $clog2(NUM_CH),
  parameter int DW_W   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_CH-1:0]       ch_mask,
  input  logic [NUM_CH*WIDTH-1:0] din,
  input  logic [DW_W-1:0]         dwell,
  output logic [WIDTH-1:0]        dout,
  output logic                    dout_valid,
  output logic [SEL_W-1:0]        cur_ch,
  output logic                    wrap
);

  typedef enum logic {ST_DWELL, ST_NONE} state_t;

  state_t            r_state;
  logic [SEL_W-1:0]  r_cur_ch;
  logic [DW_W-1:0]   r_cnt;
  logic [WIDTH-1:0]  r_dout;
  logic              r_valid;
  logic              r_wrap;

  logic [WIDTH-1:0]  w_ch [NUM_CH];
  logic [SEL_W-1:0]  w_up;
  logic [SEL_W-1:0]  w_low;
  logic              w_up_found;
  logic [SEL_W-1:0]  w_adv;
  logic              w_cur_elig;
  logic              w_sel_ok;

  state_t            w_state_nx;
  logic [SEL_W-1:0]  w_ch_nx;
  logic [DW_W-1:0]   w_cnt_nx;
  logic [WIDTH-1:0]  w_dout_nx;
  logic              w_valid_nx;
  logic              w_wrap_nx;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      w_ch[i] = din[i*WIDTH +: WIDTH];
    end
  end

  // Descending sweep: the last hit is the lowest index, both overall and above cur_ch.
  always_comb begin
    w_up       = '0;
    w_low      = '0;
    w_up_found = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_mask[i]) begin
        w_low = SEL_W'(i);
        if (i > int'(r_cur_ch)) begin
          w_up       = SEL_W'(i);
          w_up_found = 1'b1;
        end
      end
    end
    w_adv = w_up_found ? w_up : w_low;
  end

  assign w_cur_elig = (int'(r_cur_ch) < NUM_CH) && ch_mask[r_cur_ch];
  assign w_sel_ok   = (int'(sel) < NUM_CH) && ch_mask[sel];

  always_comb begin
    w_state_nx = r_state;
    w_ch_nx    = r_cur_ch;
    w_cnt_nx   = r_cnt;
    w_dout_nx  = r_dout;
    w_valid_nx = 1'b0;
    w_wrap_nx  = 1'b0;
    if (en) begin
      if (!mode) begin
        w_state_nx = ST_DWELL;
        w_cnt_nx   = '0;
        w_ch_nx    = sel;
        w_valid_nx = w_sel_ok;
        w_dout_nx  = w_sel_ok ? w_ch[sel] : '0;
      end else if (ch_mask == '0) begin
        w_state_nx = ST_NONE;
        w_cnt_nx   = '0;
        w_dout_nx  = '0;
      end else begin
        w_state_nx = ST_DWELL;
        // A masked current channel or a shortened dwell both count as expiry.
        if (r_state == ST_NONE || !w_cur_elig || r_cnt >= dwell) begin
          w_ch_nx   = w_adv;
          w_cnt_nx  = '0;
          w_wrap_nx = (w_adv <= r_cur_ch);
        end else begin
          w_cnt_nx  = r_cnt + DW_W'(1);
        end
        w_valid_nx = 1'b1;
        w_dout_nx  = w_ch[w_ch_nx];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_DWELL;
      r_cur_ch <= '0;
      r_cnt    <= '0;
      r_dout   <= '0;
      r_valid  <= 1'b0;
      r_wrap   <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_cur_ch <= w_ch_nx;
      r_cnt    <= w_cnt_nx;
      r_dout   <= w_dout_nx;
      r_valid  <= w_valid_nx;
      r_wrap   <= w_wrap_nx;
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_valid;
  assign cur_ch     = r_cur_ch;
  assign wrap       = r_wrap;

endmodule
